// File: rtl/hex_display_pkg.sv
//==============================================================================
// Module      : hex_display_pkg
// Description : Shared types and nibble-to-segment mapping for the hex scanner.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package hex_display_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [1:0] digit_idx_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}
   function automatic seg_t nib2seg(input logic [3:0] nib);
      seg_t seg;
      seg = SEG_BLANK;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hex_seg_decode.sv
//==============================================================================
// Module      : hex_seg_decode
// Description : Combinational nibble to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module hex_seg_decode
   import hex_display_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = nib2seg(nib_i);

endmodule

`default_nettype wire

// File: rtl/hex_display_scanner.sv
//==============================================================================
// Module      : hex_display_scanner
// Description : Frame-coherent 4-digit multiplexed 7-segment scanner.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module hex_display_scanner
   import hex_display_pkg::*;
#(
   parameter int          SCAN_DIV  = 50000,
   parameter logic [15:0] RESET_VAL = 16'h0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        enable,
   input  logic [15:0] in_value,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        blank_lead,
   input  logic [3:0]  dp_mask,
   output logic [7:0]  hex_seg,
   output logic [3:0]  hex_grid
);

   localparam int                 PRESC_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] c_PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
   localparam logic [3:0]         c_GRID_OFF  = 4'b1111;
   localparam logic [3:0]         c_GRID_RST  = 4'b1110;
   localparam logic [7:0]         c_SEG_RST   = {1'b1, nib2seg(RESET_VAL[3:0])};

   logic [PRESC_W-1:0] presc_q, presc_d;
   digit_idx_t         idx_q, idx_d;
   logic [15:0]        disp_q, disp_d;
   logic [15:0]        pend_q, pend_d;
   logic               pend_v_q, pend_v_d;
   logic [3:0]         grid_q, grid_d;
   logic [7:0]         seg_q, seg_d;

   logic               tick;
   logic               swap;
   logic               accept;
   logic [3:0]         nib;
   logic [6:0]         dec_seg;
   logic               blank;

   assign tick     = enable & (presc_q == c_PRESC_MAX);
   assign swap     = tick & (idx_q == 2'd3) & pend_v_q;
   assign in_ready = ~pend_v_q | swap;
   assign accept   = in_valid & in_ready;

   always_comb begin
      presc_d  = presc_q;
      idx_d    = idx_q;
      disp_d   = disp_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      if (enable) begin
         presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      end
      if (tick) begin
         idx_d = idx_q + 2'd1;
      end
      if (swap) begin
         disp_d   = pend_q;
         pend_v_d = 1'b0;
      end
      // Accept after swap so a same-cycle offer refills the buffer just drained
      if (accept) begin
         pend_d   = in_value;
         pend_v_d = 1'b1;
      end
   end

   // Outputs are computed from next-state so the new digit appears with the new index
   assign nib = disp_d[{idx_d, 2'b00} +: 4];

   hex_seg_decode u_dec (
      .nib_i (nib),
      .seg_o (dec_seg)
   );

   always_comb begin
      blank = 1'b0;
      case (idx_d)
         2'd1:    blank = blank_lead & (disp_d[15:4]  == 12'h0);
         2'd2:    blank = blank_lead & (disp_d[15:8]  == 8'h0);
         2'd3:    blank = blank_lead & (disp_d[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end

   always_comb begin
      grid_d = enable ? ~(4'b0001 << idx_d) : c_GRID_OFF;
      seg_d  = {~dp_mask[idx_d], blank ? SEG_BLANK : dec_seg};
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         presc_q  <= '0;
         idx_q    <= '0;
         disp_q   <= RESET_VAL;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         grid_q   <= c_GRID_RST;
         seg_q    <= c_SEG_RST;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         grid_q   <= grid_d;
         seg_q    <= seg_d;
      end
   end

   assign hex_grid = grid_q;
   assign hex_seg  = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
//==============================================================================
// Module      : tb_hex_display_scanner
// Description : Scoreboard bench for hex_display_scanner (SCAN_DIV=4).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hex_display_scanner;

   logic        Clk        = 1'b0;
   logic        Reset      = 1'b0;
   logic        enable     = 1'b1;
   logic [15:0] in_value   = 16'h0;
   logic        in_valid   = 1'b0;
   logic        blank_lead = 1'b0;
   logic [3:0]  dp_mask    = 4'h0;
   logic        in_ready;
   logic [7:0]  hex_seg;
   logic [3:0]  hex_grid;

   hex_display_scanner #(
      .SCAN_DIV  (4),
      .RESET_VAL (16'h0)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .enable     (enable),
      .in_value   (in_value),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .blank_lead (blank_lead),
      .dp_mask    (dp_mask),
      .hex_seg    (hex_seg),
      .hex_grid   (hex_grid)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0] grid;
      logic [7:0] seg;
      int         dwell;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks  = 0;
   int         n_fail    = 0;
   int         t         = 0;
   logic       mon_en    = 1'b0;
   logic [3:0] last_grid = 4'hx;
   int         run       = 0;
   int         cur_dwell = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
      end
   endtask

   task automatic push(input logic [3:0] g, input logic [7:0] s, input int dw);
      exp_t e;
      e.grid  = g;
      e.seg   = s;
      e.dwell = dw;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3, input int last_dw);
      push(4'b1110, s0, 4);
      push(4'b1101, s1, 4);
      push(4'b1011, s2, 4);
      push(4'b0111, s3, last_dw);
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge Clk);
         #1;
         t++;
      end
   endtask

   task automatic wait_until(input int tgt);
      if (tgt > t) step(tgt - t);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!in_ready && n < 40) begin
         step(1);
         n++;
      end
   endtask

   // Monitor: every change of digit select is a new displayed digit
   always @(negedge Clk) begin : mon
      exp_t e;
      if (mon_en) begin
         if (hex_grid !== last_grid) begin
            if (cur_dwell != 0) check("digit_dwell", 32'(run), 32'(cur_dwell));
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("grid", 32'(hex_grid), 32'(e.grid));
               check("seg", 32'(hex_seg), 32'(e.seg));
               cur_dwell = e.dwell;
            end else begin
               cur_dwell = 0;
            end
            run       = 1;
            last_grid = hex_grid;
         end else begin
            run++;
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      step(2);
      check("rst_grid", 32'(hex_grid), 32'h0E);
      check("rst_seg", 32'(hex_seg), 32'hC0);
      check("rst_ready", 32'(in_ready), 32'd1);

      // Frames 0,1 show reset value; frame 2 shows 3A5F
      push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4);
      push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4);
      t      = 0;
      Reset  = 1'b1;
      mon_en = 1'b1;

      wait_until(21);
      check("ready_idle", 32'(in_ready), 32'd1);
      in_value = 16'h3A5F;
      in_valid = 1'b1;
      push_frame(8'h8E, 8'h92, 8'h88, 8'hB0, 4);
      step(1);
      in_valid = 1'b0;
      check("ready_after_accept", 32'(in_ready), 32'd0);
      wait_until(30);
      check("ready_held_low", 32'(in_ready), 32'd0);
      wait_until(31);
      check("ready_swap_cycle", 32'(in_ready), 32'd1);

      // Back-to-back: 1234 accepted on the swap edge, ABCD held until ready
      in_value = 16'h1234;
      in_valid = 1'b1;
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4);
      push_frame(8'hA1, 8'hC6, 8'h83, 8'h88, 4);
      step(1);
      in_value = 16'hABCD;
      wait_ready(n);
      check("hold_wait_abcd", 32'(n), 32'd15);
      step(1);

      // Leading-zero blanking with a decimal point on digit 2
      in_value = 16'h0007;
      wait_ready(n);
      check("hold_wait_0007", 32'(n), 32'd15);
      step(1);
      in_valid = 1'b0;
      push_frame(8'hF8, 8'hFF, 8'h7F, 8'hFF, 4);
      wait_until(79);
      blank_lead = 1'b1;
      dp_mask    = 4'b0100;

      // Disable for 10 cycles in the middle of digit 2
      push(4'b1110, 8'hF8, 4);
      push(4'b1101, 8'hFF, 4);
      push(4'b1011, 8'h7F, 2);
      push(4'b1111, 8'h7F, 10);
      push(4'b1011, 8'h7F, 2);
      push(4'b0111, 8'hFF, 4);
      push_frame(8'h8E, 8'h86, 8'h06, 8'h83, 0);
      wait_until(105);
      enable = 1'b0;
      step(1);
      check("grid_dark", 32'(hex_grid), 32'h0F);
      wait_until(108);
      check("ready_disabled", 32'(in_ready), 32'd1);
      in_value = 16'hBEEF;
      in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      check("ready_pending_disabled", 32'(in_ready), 32'd0);
      wait_until(115);
      enable = 1'b1;
      wait_until(121);
      check("ready_swap_after_enable", 32'(in_ready), 32'd1);

      // Reset mid-frame with a pending value
      wait_until(124);
      in_value = 16'h5555;
      in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      check("ready_pending_5555", 32'(in_ready), 32'd0);
      wait_until(135);
      mon_en     = 1'b0;
      check("sb_drained_before_reset", 32'(exp_q.size()), 32'd0);
      blank_lead = 1'b0;
      dp_mask    = 4'h0;
      Reset      = 1'b0;
      #1;
      check("async_rst_grid", 32'(hex_grid), 32'h0E);
      check("async_rst_seg", 32'(hex_seg), 32'hC0);
      check("async_rst_ready", 32'(in_ready), 32'd1);
      step(2);
      push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4);
      push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 0);
      last_grid = 4'hx;
      cur_dwell = 0;
      run       = 0;
      t         = 0;
      Reset     = 1'b1;
      mon_en    = 1'b1;
      wait_until(30);
      check("ready_after_reset", 32'(in_ready), 32'd1);
      mon_en = 1'b0;
      check("sb_drained_end", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
